// File: rtl/l2_arb_pkg.sv
// rtl/l2_arb_pkg.sv - shared types and round-robin pick function for the L2 bank TCDM arbiter
package l2_arb_pkg;

   // Tag width is sized for the largest supported master count so that
   // the response tag type can be shared without package parameters.
   localparam int unsigned MAX_MASTERS = 16;
   localparam int unsigned IDX_W       = 4;

   typedef struct packed {
      logic             valid;
      logic [IDX_W-1:0] idx;
   } resp_tag_t;

   // First requester at or after ptr, searching upward modulo nb.
   // Iterating downward lets the lowest offset win without a found flag.
   function automatic logic [IDX_W-1:0] rr_pick(
      input logic [MAX_MASTERS-1:0] req,
      input logic [IDX_W-1:0]       ptr,
      input logic [IDX_W:0]         nb
   );
      logic [IDX_W:0] cand;
      rr_pick = '0;
      for (int i = MAX_MASTERS - 1; i >= 0; i--) begin
         cand = {1'b0, ptr} + (IDX_W + 1)'(i);
         if (cand >= nb) begin
            cand = cand - nb;
         end
         if (((IDX_W + 1)'(i) < nb) && req[cand[IDX_W-1:0]]) begin
            rr_pick = cand[IDX_W-1:0];
         end
      end
   endfunction

endpackage

// File: rtl/l2_arb_resp_pipe.sv
// rtl/l2_arb_resp_pipe.sv - fixed-depth response tag shift register with synchronous clear
module l2_arb_resp_pipe
   import l2_arb_pkg::*;
#(
   parameter int unsigned DEPTH = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             in_valid,
   input  logic [IDX_W-1:0] in_idx,
   output logic             out_valid,
   output logic [IDX_W-1:0] out_idx
);

   resp_tag_t stage_q [DEPTH];

   // The bank has no response backpressure, so the pipe advances every cycle.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         stage_q[0] <= '{valid: in_valid, idx: in_idx};
         for (int i = 1; i < DEPTH; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign out_valid = stage_q[DEPTH-1].valid;
   assign out_idx   = stage_q[DEPTH-1].idx;

endmodule

// File: rtl/l2_bank_tcdm_arbiter.sv
// rtl/l2_bank_tcdm_arbiter.sv - round-robin TCDM arbiter in front of one L2 bank port
module l2_bank_tcdm_arbiter
   import l2_arb_pkg::*;
#(
   parameter int unsigned NB_MASTERS   = 3,
   parameter int unsigned RESP_LATENCY = 1,
   parameter int unsigned ADDR_WIDTH   = 32,
   parameter int unsigned DATA_WIDTH   = 32
) (
   input  logic                                  clk_i,
   input  logic                                  rst_i,
   input  logic [NB_MASTERS-1:0]                 m_req_i,
   input  logic [NB_MASTERS*ADDR_WIDTH-1:0]      m_add_i,
   input  logic [NB_MASTERS-1:0]                 m_wen_i,
   input  logic [NB_MASTERS*DATA_WIDTH-1:0]      m_wdata_i,
   input  logic [NB_MASTERS*(DATA_WIDTH/8)-1:0]  m_be_i,
   output logic [NB_MASTERS-1:0]                 m_gnt_o,
   output logic [NB_MASTERS-1:0]                 m_r_valid_o,
   output logic [DATA_WIDTH-1:0]                 m_r_rdata_o,
   output logic                                  m_r_opc_o,
   output logic                                  s_req_o,
   output logic [ADDR_WIDTH-1:0]                 s_add_o,
   output logic                                  s_wen_o,
   output logic [DATA_WIDTH-1:0]                 s_wdata_o,
   output logic [DATA_WIDTH/8-1:0]               s_be_o,
   input  logic                                  s_gnt_i,
   input  logic                                  s_r_valid_i,
   input  logic [DATA_WIDTH-1:0]                 s_r_rdata_i,
   input  logic                                  s_r_opc_i
);

   localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
   localparam int unsigned PTR_W    = $clog2(NB_MASTERS);

   logic [PTR_W-1:0] rr_ptr_q;
   logic [IDX_W-1:0] winner;
   logic             accept;
   logic             pipe_valid;
   logic [IDX_W-1:0] pipe_idx;

   assign winner  = rr_pick(MAX_MASTERS'(m_req_i), IDX_W'(rr_ptr_q), (IDX_W + 1)'(NB_MASTERS));
   assign s_req_o = |m_req_i;
   assign accept  = s_req_o & s_gnt_i;

   // Request mux and grant steering; idle outputs are parked at zero.
   always_comb begin
      s_add_o   = '0;
      s_wen_o   = 1'b0;
      s_wdata_o = '0;
      s_be_o    = '0;
      m_gnt_o   = '0;
      for (int k = 0; k < NB_MASTERS; k++) begin
         if (s_req_o && (winner == IDX_W'(k))) begin
            s_add_o    = m_add_i[k*ADDR_WIDTH +: ADDR_WIDTH];
            s_wen_o    = m_wen_i[k];
            s_wdata_o  = m_wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
            s_be_o     = m_be_i[k*BE_WIDTH +: BE_WIDTH];
            m_gnt_o[k] = s_gnt_i;
         end
      end
   end

   // Pointer only moves on an accepted transfer so a stalled bank keeps priority.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rr_ptr_q <= '0;
      end else if (accept) begin
         rr_ptr_q <= (winner == IDX_W'(NB_MASTERS - 1)) ? '0 : PTR_W'(winner + 1'b1);
      end
   end

   l2_arb_resp_pipe #(
      .DEPTH (RESP_LATENCY)
   ) u_resp_pipe (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .in_valid  (accept),
      .in_idx    (winner),
      .out_valid (pipe_valid),
      .out_idx   (pipe_idx)
   );

   // Writes are tracked too: the bank answers every accepted transfer.
   always_comb begin
      m_r_valid_o = '0;
      for (int k = 0; k < NB_MASTERS; k++) begin
         m_r_valid_o[k] = s_r_valid_i & pipe_valid & (pipe_idx == IDX_W'(k));
      end
   end

   assign m_r_rdata_o = s_r_rdata_i;
   assign m_r_opc_o   = s_r_opc_i;

endmodule
